uart_rx_cmd_ctrl: RTL and testbench



---
 rtl/uart_rx_cmd_ctrl_pkg.sv | 31 +++
 rtl/uart_rx_cmd_ctrl_if.sv | 47 ++++
 rtl/uart_rx_cmd_ctrl_sender.sv | 49 ++++
 rtl/uart_rx_cmd_ctrl.sv | 158 +++++++++++++++
 tb/tb_uart_rx_cmd_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_cmd_ctrl_pkg.sv
// Shared widths, command codes, operand addresses and FSM state type
// for the UART command sequencer.
package uart_rx_cmd_ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int FUN_W  = 4;

  localparam logic [DATA_W-1:0] CMD_WR      = 8'hAA;
  localparam logic [DATA_W-1:0] CMD_RD      = 8'hBB;
  localparam logic [DATA_W-1:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [DATA_W-1:0] CMD_ALU_NOP = 8'hDD;

  localparam logic [ADDR_W-1:0] OPA_ADDR = 4'd0;
  localparam logic [ADDR_W-1:0] OPB_ADDR = 4'd1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OPA,
    OPB,
    FUN,
    ALU_WAIT,
    TX_B0,
    TX_B1
  } state_e;

endpackage

// File: rtl/uart_rx_cmd_ctrl_if.sv
// Bus bundle between the command sequencer and its surroundings:
// UART receive bytes, register file, ALU and UART transmit handshake.
interface uart_rx_cmd_ctrl_if;
  import uart_rx_cmd_ctrl_pkg::*;

  logic [DATA_W-1:0]   rx_p_data;
  logic                rx_d_vld;
  logic                rx_par_err;
  logic                rx_stp_err;

  logic                rf_wr_en;
  logic                rf_rd_en;
  logic [ADDR_W-1:0]   rf_addr;
  logic [DATA_W-1:0]   rf_wr_data;
  logic [DATA_W-1:0]   rf_rd_data;
  logic                rf_rd_vld;

  logic                alu_en;
  logic [FUN_W-1:0]    alu_fun;
  logic [2*DATA_W-1:0] alu_out;
  logic                alu_vld;

  logic [DATA_W-1:0]   tx_data;
  logic                tx_vld;
  logic                tx_rdy;

  modport master (
    input  rx_p_data, rx_d_vld, rx_par_err, rx_stp_err,
    output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data,
    input  rf_rd_data, rf_rd_vld,
    output alu_en, alu_fun,
    input  alu_out, alu_vld,
    output tx_data, tx_vld,
    input  tx_rdy
  );

  modport slave (
    output rx_p_data, rx_d_vld, rx_par_err, rx_stp_err,
    input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data,
    output rf_rd_data, rf_rd_vld,
    input  alu_en, alu_fun,
    output alu_out, alu_vld,
    input  tx_data, tx_vld,
    output tx_rdy
  );

endinterface

// File: rtl/uart_rx_cmd_ctrl_sender.sv
// Two-byte response holding register; presents bytes low-first over a
// valid/ready handshake after being loaded with a byte count of 1 or 2.
module uart_tx_rsp_sender
  import uart_rx_cmd_ctrl_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [2*DATA_W-1:0] load_data_i,
  input  logic [1:0]          load_cnt_i,
  input  logic                tx_rdy_i,
  output logic [DATA_W-1:0]   tx_data_o,
  output logic                tx_vld_o,
  output logic                accept_o,
  output logic                more_o
);

  logic [2*DATA_W-1:0] data_q, data_d;
  logic [1:0]          cnt_q, cnt_d;

  assign tx_vld_o  = (cnt_q != 2'd0);
  assign accept_o  = tx_vld_o & tx_rdy_i;
  assign more_o    = (cnt_q == 2'd2);
  assign tx_data_o = data_q[DATA_W-1:0];

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      data_d = load_data_i;
      cnt_d  = load_cnt_i;
    end else if (accept_o) begin
      // shift the high byte down so it is presented the very next cycle
      data_d = {{DATA_W{1'b0}}, data_q[2*DATA_W-1:DATA_W]};
      cnt_d  = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_cmd_ctrl.sv
// Command sequencer: frames UART bytes into RF write/read and ALU commands and
// returns responses. Define RX_ERR_DROP_EN to abort frames on errored bytes.
module uart_rx_cmd_ctrl
  import uart_rx_cmd_ctrl_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  uart_rx_cmd_ctrl_if.master  bus,
  output logic                busy_o
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_lat_q, addr_lat_d;
  logic                rf_wr_en_q, rf_wr_en_d;
  logic                rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic                alu_en_q, alu_en_d;
  logic [FUN_W-1:0]    alu_fun_q, alu_fun_d;

  logic                ld;
  logic [2*DATA_W-1:0] ld_data;
  logic [1:0]          ld_cnt;
  logic                tx_accept;
  logic                tx_more;
  logic                rx_ok;

`ifdef RX_ERR_DROP_EN
  logic rx_bad;
  assign rx_bad = bus.rx_d_vld & (bus.rx_par_err | bus.rx_stp_err);
  assign rx_ok  = bus.rx_d_vld & ~rx_bad;
`else
  assign rx_ok  = bus.rx_d_vld;
`endif

  always_comb begin
    state_d      = state_q;
    addr_lat_d   = addr_lat_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_fun_d    = alu_fun_q;
    ld           = 1'b0;
    ld_data      = '0;
    ld_cnt       = 2'd0;

    case (state_q)
      IDLE: if (rx_ok) begin
        case (bus.rx_p_data)
          CMD_WR:      state_d = WR_ADDR;
          CMD_RD:      state_d = RD_ADDR;
          CMD_ALU_OP:  state_d = OPA;
          CMD_ALU_NOP: state_d = FUN;
          default:     state_d = IDLE;
        endcase
      end
      WR_ADDR: if (rx_ok) begin
        addr_lat_d = bus.rx_p_data[ADDR_W-1:0];
        state_d    = WR_DATA;
      end
      WR_DATA: if (rx_ok) begin
        rf_wr_en_d   = 1'b1;
        rf_addr_d    = addr_lat_q;
        rf_wr_data_d = bus.rx_p_data;
        state_d      = IDLE;
      end
      RD_ADDR: if (rx_ok) begin
        rf_rd_en_d = 1'b1;
        rf_addr_d  = bus.rx_p_data[ADDR_W-1:0];
        state_d    = RD_WAIT;
      end
      RD_WAIT: if (bus.rf_rd_vld) begin
        ld      = 1'b1;
        ld_data = {{DATA_W{1'b0}}, bus.rf_rd_data};
        ld_cnt  = 2'd1;
        state_d = TX_B0;
      end
      OPA: if (rx_ok) begin
        rf_wr_en_d   = 1'b1;
        rf_addr_d    = OPA_ADDR;
        rf_wr_data_d = bus.rx_p_data;
        state_d      = OPB;
      end
      OPB: if (rx_ok) begin
        rf_wr_en_d   = 1'b1;
        rf_addr_d    = OPB_ADDR;
        rf_wr_data_d = bus.rx_p_data;
        state_d      = FUN;
      end
      FUN: if (rx_ok) begin
        alu_en_d  = 1'b1;
        alu_fun_d = bus.rx_p_data[FUN_W-1:0];
        state_d   = ALU_WAIT;
      end
      ALU_WAIT: if (bus.alu_vld) begin
        ld      = 1'b1;
        ld_data = bus.alu_out;
        ld_cnt  = 2'd2;
        state_d = TX_B0;
      end
      TX_B0: if (tx_accept) state_d = tx_more ? TX_B1 : IDLE;
      TX_B1: if (tx_accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef RX_ERR_DROP_EN
    // only byte-collecting states own a frame; wait/TX states drop RX anyway
    if (rx_bad && (state_q inside {WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN}))
      state_d = IDLE;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_lat_q   <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      alu_en_q     <= 1'b0;
      alu_fun_q    <= '0;
    end else begin
      state_q      <= state_d;
      addr_lat_q   <= addr_lat_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      alu_en_q     <= alu_en_d;
      alu_fun_q    <= alu_fun_d;
    end
  end

  uart_tx_rsp_sender u_sender (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (ld),
    .load_data_i (ld_data),
    .load_cnt_i  (ld_cnt),
    .tx_rdy_i    (bus.tx_rdy),
    .tx_data_o   (bus.tx_data),
    .tx_vld_o    (bus.tx_vld),
    .accept_o    (tx_accept),
    .more_o      (tx_more)
  );

  assign bus.rf_wr_en   = rf_wr_en_q;
  assign bus.rf_rd_en   = rf_rd_en_q;
  assign bus.rf_addr    = rf_addr_q;
  assign bus.rf_wr_data = rf_wr_data_q;
  assign bus.alu_en     = alu_en_q;
  assign bus.alu_fun    = alu_fun_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Directed bench for uart_rx_cmd_ctrl with RF/ALU responders and a scoreboard
// of expected RF writes, RF reads, ALU starts and TX bytes.
module tb_uart_rx_cmd_ctrl;
  import uart_rx_cmd_ctrl_pkg::*;

  logic clk;
  logic rst;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_wr_q[$];
  logic [3:0] exp_rd_q[$];
  logic [3:0] exp_alu_q[$];
  logic [7:0] exp_tx_q[$];

  logic [15:0] alu_res;
  logic [7:0]  rf_mem [16];
  int          alu_cnt;

  uart_rx_cmd_ctrl_if bus ();

  uart_rx_cmd_ctrl dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus),
    .busy_o (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // register-file responder: read data one cycle after the read strobe
  always @(posedge clk) begin
    if (rst) begin
      bus.rf_rd_vld  <= 1'b0;
      bus.rf_rd_data <= 8'h00;
      for (int i = 0; i < 16; i++) rf_mem[i] <= 8'h00;
    end else begin
      bus.rf_rd_vld <= bus.rf_rd_en;
      if (bus.rf_rd_en) bus.rf_rd_data <= rf_mem[bus.rf_addr];
      if (bus.rf_wr_en) rf_mem[bus.rf_addr] <= bus.rf_wr_data;
    end
  end

  // ALU responder: result valid a few cycles after the start strobe
  always @(posedge clk) begin
    if (rst) begin
      alu_cnt     <= 0;
      bus.alu_vld <= 1'b0;
      bus.alu_out <= 16'h0000;
    end else begin
      bus.alu_vld <= (alu_cnt == 1);
      if (bus.alu_en) begin
        alu_cnt     <= 3;
        bus.alu_out <= alu_res;
      end else if (alu_cnt != 0) begin
        alu_cnt <= alu_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic pe = 1'b0, input logic se = 1'b0);
    bus.rx_p_data  = b;
    bus.rx_par_err = pe;
    bus.rx_stp_err = se;
    bus.rx_d_vld   = 1'b1;
    tick();
    bus.rx_d_vld   = 1'b0;
    bus.rx_par_err = 1'b0;
    bus.rx_stp_err = 1'b0;
  endtask

  task automatic wait_tx(input string tag);
    int n = 0;
    while (!bus.tx_vld && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.tx_vld), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 0);
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_wr_en"},   32'(bus.rf_wr_en),   0);
    check({tag, "_rd_en"},   32'(bus.rf_rd_en),   0);
    check({tag, "_addr"},    32'(bus.rf_addr),    0);
    check({tag, "_wdata"},   32'(bus.rf_wr_data), 0);
    check({tag, "_alu_en"},  32'(bus.alu_en),     0);
    check({tag, "_alu_fun"}, 32'(bus.alu_fun),    0);
    check({tag, "_tx_data"}, 32'(bus.tx_data),    0);
    check({tag, "_tx_vld"},  32'(bus.tx_vld),     0);
    check({tag, "_busy"},    32'(busy),           0);
  endtask

  initial begin
    wr_t w;
    rst            = 1'b1;
    bus.rx_p_data  = 8'h00;
    bus.rx_d_vld   = 1'b0;
    bus.rx_par_err = 1'b0;
    bus.rx_stp_err = 1'b0;
    bus.tx_rdy     = 1'b0;
    alu_res        = 16'h0000;

    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (bus.rf_wr_en) begin
            check("sb_wr_expected", 32'(exp_wr_q.size() != 0), 1);
            if (exp_wr_q.size() != 0) begin
              w = exp_wr_q.pop_front();
              check("sb_wr_addr", 32'(bus.rf_addr), 32'(w.a));
              check("sb_wr_data", 32'(bus.rf_wr_data), 32'(w.d));
            end
          end
          if (bus.rf_rd_en) begin
            check("sb_rd_expected", 32'(exp_rd_q.size() != 0), 1);
            if (exp_rd_q.size() != 0) check("sb_rd_addr", 32'(bus.rf_addr), 32'(exp_rd_q.pop_front()));
          end
          if (bus.alu_en) begin
            check("sb_alu_expected", 32'(exp_alu_q.size() != 0), 1);
            if (exp_alu_q.size() != 0) check("sb_alu_fun", 32'(bus.alu_fun), 32'(exp_alu_q.pop_front()));
          end
          if (bus.tx_vld && bus.tx_rdy) begin
            check("sb_tx_expected", 32'(exp_tx_q.size() != 0), 1);
            if (exp_tx_q.size() != 0) check("sb_tx_data", 32'(bus.tx_data), 32'(exp_tx_q.pop_front()));
          end
        end
      end
    join_none

    repeat (3) tick();
    check_outs_zero("reset");
    rst = 1'b0;
    tick();

    // plain write
    exp_wr_q.push_back('{a: 4'h5, d: 8'h3C});
    send_byte(CMD_WR);
    send_byte(8'h05);
    send_byte(8'h3C);
    check("wr_strobe", 32'(bus.rf_wr_en), 1);
    check("wr_addr", 32'(bus.rf_addr), 'h5);
    check("wr_data", 32'(bus.rf_wr_data), 'h3C);
    check("wr_busy", 32'(busy), 0);
    tick();
    check("wr_strobe_1cyc", 32'(bus.rf_wr_en), 0);
    check("wr_no_tx", 32'(bus.tx_vld), 0);
    check("wr_addr_hold", 32'(bus.rf_addr), 'h5);

    // write then read back with a stalled transmitter (upper addr bits ignored)
    exp_wr_q.push_back('{a: 4'h2, d: 8'h7E});
    send_byte(CMD_WR);
    send_byte(8'hF2);
    send_byte(8'h7E);
    exp_rd_q.push_back(4'h2);
    exp_tx_q.push_back(8'h7E);
    send_byte(CMD_RD);
    send_byte(8'h02);
    check("rd_strobe", 32'(bus.rf_rd_en), 1);
    check("rd_busy", 32'(busy), 1);
    wait_tx("rd_tx_vld");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rd_hold_vld", 32'(bus.tx_vld), 1);
      check("rd_hold_data", 32'(bus.tx_data), 'h7E);
    end
    bus.tx_rdy = 1'b1;
    tick();
    bus.tx_rdy = 1'b0;
    check("rd_done_vld", 32'(bus.tx_vld), 0);
    check("rd_done_busy", 32'(busy), 0);

    // ALU with operands, low byte then high byte
    alu_res = 16'h000D;
    exp_wr_q.push_back('{a: 4'h0, d: 8'h0A});
    exp_wr_q.push_back('{a: 4'h1, d: 8'h03});
    exp_alu_q.push_back(4'h0);
    exp_tx_q.push_back(8'h0D);
    exp_tx_q.push_back(8'h00);
    send_byte(CMD_ALU_OP);
    send_byte(8'h0A);
    send_byte(8'h03);
    send_byte(8'h00);
    check("aluop_en", 32'(bus.alu_en), 1);
    wait_tx("aluop_tx_vld");
    check("aluop_b0", 32'(bus.tx_data), 'h0D);
    bus.tx_rdy = 1'b1;
    tick();
    bus.tx_rdy = 1'b0;
    check("aluop_b1_vld", 32'(bus.tx_vld), 1);
    check("aluop_b1", 32'(bus.tx_data), 'h00);
    check("aluop_b1_busy", 32'(busy), 1);
    bus.tx_rdy = 1'b1;
    tick();
    bus.tx_rdy = 1'b0;
    check("aluop_end_vld", 32'(bus.tx_vld), 0);
    check("aluop_end_busy", 32'(busy), 0);

    // ALU without operands; a stray byte during ALU_WAIT must be dropped
    alu_res = 16'h1234;
    exp_alu_q.push_back(4'h2);
    exp_tx_q.push_back(8'h34);
    exp_tx_q.push_back(8'h12);
    bus.tx_rdy = 1'b1;
    send_byte(CMD_ALU_NOP);
    send_byte(8'hA2);
    check("alunop_fun", 32'(bus.alu_fun), 'h2);
    tick();
    send_byte(CMD_WR);
    wait_idle("alunop_idle");
    bus.tx_rdy = 1'b0;
    tick();
    check("alunop_drop_busy", 32'(busy), 0);
    check("alunop_fun_hold", 32'(bus.alu_fun), 'h2);

`ifdef RX_ERR_DROP_EN
    send_byte(CMD_WR);
    send_byte(8'h05, 1'b1, 1'b0);
    check("err_abort_busy", 32'(busy), 0);
    send_byte(CMD_WR, 1'b0, 1'b1);
    check("err_idle_ignored", 32'(busy), 0);
    exp_wr_q.push_back('{a: 4'h5, d: 8'h3C});
    send_byte(CMD_WR);
    send_byte(8'h05);
    send_byte(8'h3C);
    check("err_after_wr", 32'(bus.rf_wr_en), 1);
`else
    exp_wr_q.push_back('{a: 4'h5, d: 8'h3C});
    send_byte(CMD_WR);
    send_byte(8'h05, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b0, 1'b1);
    check("err_as_data_wr", 32'(bus.rf_wr_en), 1);
    check("err_as_data_busy", 32'(busy), 0);
`endif
    tick();

    // unknown command, then reset mid-frame
    send_byte(8'h55);
    check("unknown_busy", 32'(busy), 0);
    send_byte(CMD_RD);
    check("midframe_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    check_outs_zero("midrst");
    rst = 1'b0;
    tick();
    exp_wr_q.push_back('{a: 4'h9, d: 8'h5A});
    send_byte(CMD_WR);
    send_byte(8'h09);
    send_byte(8'h5A);
    check("post_rst_wr", 32'(bus.rf_wr_en), 1);
    check("post_rst_addr", 32'(bus.rf_addr), 'h9);

    repeat (4) tick();
    check("left_wr", exp_wr_q.size(), 0);
    check("left_rd", exp_rd_q.size(), 0);
    check("left_alu", exp_alu_q.size(), 0);
    check("left_tx", exp_tx_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
